// File: rtl/dmem_wbuf.sv
// Data memory (64x32) behind a FIFO write buffer drained by a latency-modelling FSM.
// Define DMEM_WBUF_FWD_EN to forward buffered store data to loads instead of stalling them.
module dmem_wbuf #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DRAIN_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic [3:0]  wbuf_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic            full_q, full_d;
    logic [5:0]      idx_q  [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     ram_q  [64];

    logic [5:0]      rd_idx;
    logic [PtrW-1:0] occ;
    logic [PtrW-1:0] tail_inc;
    logic [PtrW-1:0] slot;
    logic            push, pop;
    logic            match_any;
    logic            unused_adr;

    assign rd_idx     = dataadr[7:2];
    assign unused_adr = ^{dataadr[31:8], dataadr[1:0]};
    assign occ        = tail_q - head_q;
    assign tail_inc   = tail_q + PtrW'(1);
    assign wbuf_count = full_q ? 4'(DEPTH) : 4'(occ);

    // A full buffer blocks the store even in a cycle where COMMIT pops.
    assign push = memwrite && !full_q;
    assign pop  = (state_q == StCommit);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        full_d = full_q;
        if (push) tail_d = tail_inc;
        if (pop)  head_d = head_q + PtrW'(1);
        if (push && !pop)      full_d = (tail_inc == head_q);
        else if (pop && !push) full_d = 1'b0;
    end

`ifdef DMEM_WBUF_FWD_EN
    logic [31:0] fwd_data;
`endif

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        match_any = 1'b0;
        slot      = '0;
`ifdef DMEM_WBUF_FWD_EN
        fwd_data  = ram_q[rd_idx];
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_q + PtrW'(i);
            if ((i < 32'(wbuf_count)) && (idx_q[slot] == rd_idx)) begin
                match_any = 1'b1;
`ifdef DMEM_WBUF_FWD_EN
                fwd_data  = data_q[slot];
`endif
            end
        end
    end

`ifdef DMEM_WBUF_FWD_EN
    assign readdata = (!reset && !memwrite && match_any) ? fwd_data : ram_q[rd_idx];
    assign stall    = !reset && memwrite && full_q;
`else
    assign readdata = ram_q[rd_idx];
    assign stall    = !reset && (memwrite ? full_q : match_any);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            full_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            full_q <= full_d;
        end
    end

    // Counter restarts at 1 from IDLE but at 0 after a COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wbuf_count != 4'd0) begin
                        state_q <= StDrain;
                        cnt_q   <= 4'd1;
                    end
                end
                StDrain: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (({28'd0, cnt_q} + 32'd1) >= DRAIN_LAT) state_q <= StCommit;
                end
                StCommit: begin
                    cnt_q   <= '0;
                    state_q <= ((wbuf_count > 4'd1) || push) ? StDrain : StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            idx_q[tail_q]  <= rd_idx;
            data_q[tail_q] <= writedata;
        end
    end

    // RAM is never reset; a COMMIT coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && pop) ram_q[idx_q[head_q]] <= data_q[head_q];
    end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed self-checking bench for dmem_wbuf (DEPTH=4, DRAIN_LAT=2).
module tb_dmem_wbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic [3:0]  wbuf_count;

    int checks   = 0;
    int failures = 0;

`ifdef DMEM_WBUF_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    dmem_wbuf #(
        .DEPTH     (4),
        .DRAIN_LAT (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .stall      (stall),
        .wbuf_count (wbuf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_count", 32'(wbuf_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        // Two stores, first commit 3 edges after push, second 3 edges later
        drive(1'b1, 32'd80, 32'd7);
        chk("st_nostall", 32'(stall), 32'd0);
        tick();
        chk("cnt_one", 32'(wbuf_count), 32'd1);
        drive(1'b1, 32'd84, 32'd8);
        tick();
        chk("cnt_two", 32'(wbuf_count), 32'd2);
        drive(1'b0, 32'd80, 32'd0);
        chk("ld80_stall", 32'(stall), Fwd ? 32'd0 : 32'd1);
        tick();
        tick();
        chk("ram20_commit", readdata, 32'd7);
        chk("cnt_after_c1", 32'(wbuf_count), 32'd1);
        chk("ld80_free", 32'(stall), 32'd0);
        drive(1'b0, 32'd84, 32'd0);
        tick();
        tick();
        chk("ld84_pending", 32'(stall), Fwd ? 32'd0 : 32'd1);
        tick();
        chk("ram21_commit", readdata, 32'd8);
        chk("cnt_empty", 32'(wbuf_count), 32'd0);
        chk("ld84_free", 32'(stall), 32'd0);

        // Two stores to one word, then load it
        drive(1'b1, 32'd84, 32'h11);
        tick();
        drive(1'b1, 32'd84, 32'h22);
        tick();
        drive(1'b0, 32'd84, 32'd0);
        chk("same_idx_stall", 32'(stall), Fwd ? 32'd0 : 32'd1);
        chk("same_idx_data", readdata, Fwd ? 32'h22 : 32'd8);
        tick();
        tick();
        chk("order_first", readdata, Fwd ? 32'h22 : 32'h11);
        chk("order_stall", 32'(stall), Fwd ? 32'd0 : 32'd1);
        tick();
        tick();
        tick();
        chk("order_last", readdata, 32'h22);
        chk("order_stall_off", 32'(stall), 32'd0);
        chk("order_cnt", 32'(wbuf_count), 32'd0);

        // Aliased address lands in word 21
        drive(1'b1, 32'h0001_0054, 32'hA5A5);
        tick();
        drive(1'b0, 32'd84, 32'd0);
        tick();
        tick();
        tick();
        chk("alias_data", readdata, 32'hA5A5);
        chk("alias_cnt", 32'(wbuf_count), 32'd0);

        // Back-to-back stores fill the buffer
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(k * 4), 32'h101 + 32'(k));
            tick();
        end
        chk("fill_pushpop", 32'(wbuf_count), 32'd3);
        drive(1'b1, 32'd16, 32'h105);
        tick();
        chk("fill_full", 32'(wbuf_count), 32'd4);
        drive(1'b1, 32'd20, 32'h106);
        chk("full_stall", 32'(stall), 32'd1);
        tick();
        chk("full_commit_stall", 32'(stall), 32'd1);
        chk("full_commit_cnt", 32'(wbuf_count), 32'd4);
        tick();
        chk("pop_blocks_push", 32'(wbuf_count), 32'd3);
        chk("unstall", 32'(stall), 32'd0);
        tick();
        chk("retry_accepted", 32'(wbuf_count), 32'd4);
        drive(1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 11; k++) tick();
        chk("fill_drained", 32'(wbuf_count), 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'(k * 4), 32'd0);
            chk("fill_ram", readdata, 32'h101 + 32'(k));
        end

        // Push and COMMIT in the same cycle with two entries
        drive(1'b1, 32'd120, 32'hC1);
        tick();
        drive(1'b1, 32'd124, 32'hC2);
        tick();
        drive(1'b0, 32'd120, 32'd0);
        tick();
        chk("pp_before", 32'(wbuf_count), 32'd2);
        drive(1'b1, 32'd128, 32'hC3);
        tick();
        chk("pp_count", 32'(wbuf_count), 32'd2);
        drive(1'b0, 32'd120, 32'd0);
        chk("pp_first", readdata, 32'hC1);
        tick();
        tick();
        tick();
        drive(1'b0, 32'd124, 32'd0);
        chk("pp_second", readdata, 32'hC2);
        chk("pp_second_cnt", 32'(wbuf_count), 32'd1);
        tick();
        tick();
        tick();
        drive(1'b0, 32'd128, 32'd0);
        chk("pp_third", readdata, 32'hC3);
        chk("pp_third_cnt", 32'(wbuf_count), 32'd0);

        // Reset while in COMMIT with three entries
        drive(1'b1, 32'h40, 32'hEE);
        tick();
        drive(1'b0, 32'h40, 32'd0);
        tick();
        tick();
        tick();
        chk("pre_word", readdata, 32'hEE);
        drive(1'b1, 32'h40, 32'hD1);
        tick();
        drive(1'b1, 32'h44, 32'hD2);
        tick();
        drive(1'b1, 32'h48, 32'hD3);
        tick();
        chk("commit_cnt3", 32'(wbuf_count), 32'd3);
        reset = 1'b1;
        drive(1'b0, 32'h40, 32'd0);
        chk("in_rst_stall", 32'(stall), 32'd0);
        chk("in_rst_rdata", readdata, 32'hEE);
        tick();
        chk("rst_flush_cnt", 32'(wbuf_count), 32'd0);
        chk("head_not_written", readdata, 32'hEE);
        drive(1'b0, 32'd84, 32'd0);
        chk("ram_intact", readdata, 32'hA5A5);
        reset = 1'b0;
        drive(1'b0, 32'h40, 32'd0);
        tick();
        tick();
        tick();
        tick();
        chk("post_rst_cnt", 32'(wbuf_count), 32'd0);
        chk("post_rst_word", readdata, 32'hEE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-buffer entry count (power of two, 2..8).
REQ-002 SHALL have parameter DRAIN_LAT, default 2, cycles from entering DRAIN to RAM commit (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port memwrite  input  1  store request from the CPU in this cycle.
REQ-006 SHALL have port dataadr  input  32  byte address; word index = dataadr[7:2].
REQ-007 SHALL have port writedata  input  32  store data.
REQ-008 SHALL have port readdata  output  32  combinational load data for dataadr.
REQ-009 SHALL have port stall  output  1  combinational; CPU holds its PC and retries while high.
REQ-010 SHALL have port wbuf_count  output  4  number of occupied buffer entries (0..DEPTH).

Function
REQ-011 SHALL hold a 64x32 RAM; dataadr[31:8] and dataadr[1:0] are ignored (address aliasing, no alignment error).
REQ-012 SHALL accept a store (push {index,data} at tail) on a posedge with memwrite=1 and stall=0.
REQ-013 SHALL assert stall whenever memwrite=1 and wbuf_count==DEPTH; the store is not accepted that cycle.
REQ-014 SHALL run a drain FSM with states IDLE, DRAIN, COMMIT.
REQ-015 IDLE->DRAIN when wbuf_count>0; a wait counter loads 1 on entry.
REQ-016 DRAIN increments the counter each cycle; DRAIN->COMMIT when the counter reaches DRAIN_LAT.
REQ-017 COMMIT writes the head entry into RAM, pops it, then goes to DRAIN if entries remain, else to IDLE.
REQ-018 A push and a COMMIT pop in the same cycle SHALL both take effect; wbuf_count is then unchanged.
REQ-019 A push when full is blocked even if COMMIT pops that cycle (no pass-through).
REQ-020 Head/tail pointers SHALL wrap modulo DEPTH; a full/empty flag distinguishes head==tail.
REQ-021 readdata SHALL reflect the state before the current cycle's store (a same-cycle store is not visible).
REQ-022 Buffered entries SHALL commit to RAM in push order; a later store to the same index overwrites the RAM value.

Reset
REQ-023 On reset, buffer is emptied (wbuf_count=0), pending entries are discarded, FSM goes to IDLE, and the wait counter clears.
REQ-024 Reset SHALL NOT clear RAM contents; an entry in COMMIT during a reset cycle is not written.
REQ-025 During and after reset, stall=0 while memwrite=0; readdata is the RAM word at dataadr.

Configuration
REQ-026 Macro DMEM_WBUF_FWD_EN SHALL select store-to-load forwarding.
REQ-027 With DMEM_WBUF_FWD_EN defined: when memwrite=0 and a buffered entry matches dataadr[7:2], readdata is the youngest matching entry's data, stall stays 0.
REQ-028 Without it: a load (memwrite=0) whose index matches any buffered entry asserts stall until no match remains; readdata is then from RAM.

Verification
REQ-029 Reset, then store 7 to 80 and 8 to 84 -> wbuf_count 1 then 2; with DRAIN_LAT=2, RAM[20]=7 at the 3rd posedge after the first push, and RAM[21]=8 3 cycles after that.
REQ-030 Five back-to-back stores with DEPTH=4 and no drain complete yet -> stall=1 on the 5th; that store is accepted after the first COMMIT.
REQ-031 Store 0x11 then 0x22 to address 84, then load 84 at once -> FWD_EN: readdata=0x22, stall=0; without: stall=1 until both commit, then readdata=0x22.
REQ-032 A push and a COMMIT in the same cycle with wbuf_count=2 -> wbuf_count stays 2 and entry order is preserved.
REQ-033 Reset asserted in COMMIT with 3 entries -> wbuf_count=0, FSM IDLE, head entry not in RAM, previously committed words intact.
REQ-034 Store to 0x1_0054 -> commits to the same word as 84 (aliasing); readdata at 84 returns the stored value.
